// File: rtl/issue_scoreboard_if.sv
// Decode/back-end handshake bundle for issue_scoreboard, plus FSM and counter debug taps.
// Handshake: a uop leaves decode on a cycle where issue_valid && issue_ready; issue_ready never looks at issue_valid.
interface issue_scoreboard_if #(
  parameter int OUT_W = 6
);
  logic             issue_valid;
  logic [4:0]       issue_rs1;
  logic             issue_rs1_used;
  logic [4:0]       issue_rs2;
  logic             issue_rs2_used;
  logic [4:0]       issue_rd;
  logic             issue_rd_valid;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             drain_req;
  logic             drain_done;
  logic             busy;
  logic             err_underflow;
  logic [31:0]      stall_cycles;
  logic             dbgState;
  logic [OUT_W-1:0] dbgOutstanding;

  modport master (
    output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
           issue_rd, issue_rd_valid, wb_valid, wb_rd, drain_req,
    input  issue_ready, drain_done, busy, err_underflow, stall_cycles,
           dbgState, dbgOutstanding
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
           issue_rd, issue_rd_valid, wb_valid, wb_rd, drain_req,
    output issue_ready, drain_done, busy, err_underflow, stall_cycles,
           dbgState, dbgOutstanding
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue/drain controller between decode and the back end.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle final writeback clear a source hazard.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int OUT_W    = 6
) (
  input logic               clk,
  input logic               rst,
  issue_scoreboard_if.slave sb
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} stateT;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [OUT_W-1:0] OUT_MAX = {OUT_W{1'b1}};

  stateT                state, nextState;
  logic [CNT_W-1:0]     cnt [NUM_REGS];
  logic [OUT_W-1:0]     outstanding;
  logic                 errUnderflow;
  logic [31:0]          stallCycles;

  logic                 byp1, byp2;
  logic                 hazard, full, ready, drainDone;
  logic                 fire, incEn, decEn, wbZero;
  logic [NUM_REGS-1:0]  incVec, decVec;

  // A source whose only pending write retires this cycle is forwarded by the back end.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef SCOREBOARD_WB_BYPASS_EN
    byp1 = sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && (cnt[sb.issue_rs1] == CNT_W'(1));
    byp2 = sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && (cnt[sb.issue_rs2] == CNT_W'(1));
`endif
  end

  always_comb begin
    hazard = (sb.issue_rs1_used && (sb.issue_rs1 != '0) && (cnt[sb.issue_rs1] != '0) && !byp1) ||
             (sb.issue_rs2_used && (sb.issue_rs2 != '0) && (cnt[sb.issue_rs2] != '0) && !byp2);
    full   = (sb.issue_rd_valid && (sb.issue_rd != '0) && (cnt[sb.issue_rd] == CNT_MAX)) ||
             (outstanding == OUT_MAX);
  end

  always_comb begin
    nextState = state;
    ready     = 1'b0;
    drainDone = 1'b0;
    case (state)
      IDLE: begin
        ready = !hazard && !full;
        if (sb.drain_req) nextState = DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0) begin
          drainDone = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    fire   = sb.issue_valid && ready;
    incEn  = fire && sb.issue_rd_valid && (sb.issue_rd != '0);
    decEn  = sb.wb_valid && (sb.wb_rd != '0) && (cnt[sb.wb_rd] != '0);
    wbZero = sb.wb_valid && (sb.wb_rd != '0) && (cnt[sb.wb_rd] == '0);
    incVec = '0;
    decVec = '0;
    if (incEn) incVec[sb.issue_rd] = 1'b1;
    if (decEn) decVec[sb.wb_rd]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // A fire and a retire on the same register cancel out, both per register and in total.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      outstanding <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (incVec[r] && !decVec[r])      cnt[r] <= cnt[r] + CNT_W'(1);
        else if (decVec[r] && !incVec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (incEn && !decEn)      outstanding <= outstanding + OUT_W'(1);
      else if (decEn && !incEn) outstanding <= outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errUnderflow <= 1'b0;
      stallCycles  <= '0;
    end else begin
      if (wbZero) errUnderflow <= 1'b1;
      if (sb.issue_valid && !ready && (stallCycles != '1)) stallCycles <= stallCycles + 32'd1;
    end
  end

  assign sb.issue_ready    = ready;
  assign sb.drain_done     = drainDone;
  assign sb.busy           = (outstanding != '0);
  assign sb.err_underflow  = errUnderflow;
  assign sb.stall_cycles   = stallCycles;
  assign sb.dbgState       = state;
  assign sb.dbgOutstanding = outstanding;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, full, same-cycle fire/wb, underflow, drain, reset mid-drain.
module tb_issue_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  issue_scoreboard_if sb ();

  issue_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIssue(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rdv);
    sb.issue_valid    = v;
    sb.issue_rs1      = rs1;
    sb.issue_rs1_used = u1;
    sb.issue_rs2      = rs2;
    sb.issue_rs2_used = u2;
    sb.issue_rd       = rd;
    sb.issue_rd_valid = rdv;
  endtask

  task automatic setWb(input logic v, input logic [4:0] rd);
    sb.wb_valid = v;
    sb.wb_rd    = rd;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    setIssue(0, 0, 0, 0, 0, 0, 0);
    setWb(0, 0);
    sb.drain_req = 1'b0;
    advance();
    advance();
    rst = 1'b0;

    // Reset state
    settle();
    check("rst_ready", sb.issue_ready, 1);
    check("rst_busy", sb.busy, 0);
    check("rst_done", sb.drain_done, 0);
    check("rst_err", sb.err_underflow, 0);
    check("rst_stall", sb.stall_cycles, 0);
    check("rst_state", sb.dbgState, 0);
    check("rst_out", sb.dbgOutstanding, 0);
    advance();

    // RAW hazard on r5
    setIssue(1, 0, 0, 0, 0, 5, 1);
    settle();
    check("w5_ready", sb.issue_ready, 1);
    advance();
    setIssue(1, 5, 1, 0, 0, 0, 0);
    settle();
    check("raw5_ready", sb.issue_ready, 0);
    check("raw5_busy", sb.busy, 1);
    check("raw5_out", sb.dbgOutstanding, 1);
    advance();
    setWb(1, 5);
    settle();
    check("raw5_stall1", sb.stall_cycles, 1);
    check("raw5_wb_ready", sb.issue_ready, BYP ? 1 : 0);
    advance();
    setWb(0, 0);
    settle();
    check("raw5_after_ready", sb.issue_ready, 1);
    check("raw5_after_busy", sb.busy, 0);
    check("raw5_stall2", sb.stall_cycles, BYP ? 1 : 2);
    advance();

    // Per-register full at three in-flight writes to r7
    setIssue(1, 0, 0, 0, 0, 7, 1);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("w7_ready", sb.issue_ready, 1);
      advance();
    end
    settle();
    check("full7_ready", sb.issue_ready, 0);
    check("full7_out", sb.dbgOutstanding, 3);
    advance();
    setWb(1, 7);
    settle();
    check("full7_wb_ready", sb.issue_ready, 0);
    advance();
    setWb(0, 0);
    settle();
    check("full7_out2", sb.dbgOutstanding, 2);
    check("full7_resume", sb.issue_ready, 1);
    advance();
    setIssue(0, 0, 0, 0, 0, 0, 0);
    setWb(1, 7);
    advance();
    advance();
    advance();
    setWb(0, 0);
    settle();
    check("r7_retired_out", sb.dbgOutstanding, 0);
    check("r7_stall", sb.stall_cycles, BYP ? 3 : 4);
    check("r7_err", sb.err_underflow, 0);
    advance();

    // Same-cycle fire and writeback on r3
    setIssue(1, 0, 0, 0, 0, 3, 1);
    advance();
    setWb(1, 3);
    settle();
    check("fw3_ready", sb.issue_ready, 1);
    advance();
    setWb(0, 0);
    setIssue(0, 3, 1, 0, 0, 0, 0);
    settle();
    check("fw3_out", sb.dbgOutstanding, 1);
    check("fw3_hazard", sb.issue_ready, 0);
    advance();
    setWb(1, 3);
    advance();
    setWb(0, 0);
    settle();
    check("fw3_clear_out", sb.dbgOutstanding, 0);
    check("fw3_clear_ready", sb.issue_ready, 1);
    advance();

    // Underflow on r9; x0 traffic and invalid uops leave state alone
    setIssue(0, 0, 0, 0, 0, 9, 1);
    setWb(1, 9);
    advance();
    setWb(1, 0);
    setIssue(1, 0, 0, 0, 0, 0, 1);
    settle();
    check("uf_err", sb.err_underflow, 1);
    check("uf_out", sb.dbgOutstanding, 0);
    advance();
    setWb(0, 0);
    setIssue(0, 9, 1, 0, 0, 0, 0);
    settle();
    check("x0_out", sb.dbgOutstanding, 0);
    check("x0_busy", sb.busy, 0);
    check("uf_err_sticky", sb.err_underflow, 1);
    check("r9_no_hazard", sb.issue_ready, 1);
    advance();

    // Drain with two outstanding writes; request cycle still fires one uop
    setIssue(1, 0, 0, 0, 0, 10, 1);
    advance();
    setIssue(1, 0, 0, 0, 0, 11, 1);
    sb.drain_req = 1'b1;
    settle();
    check("dr_req_ready", sb.issue_ready, 1);
    advance();
    sb.drain_req = 1'b1;
    setIssue(1, 0, 0, 0, 0, 0, 0);
    settle();
    check("dr_state", sb.dbgState, 1);
    check("dr_out", sb.dbgOutstanding, 2);
    check("dr_ready0", sb.issue_ready, 0);
    check("dr_done0", sb.drain_done, 0);
    advance();
    sb.drain_req = 1'b0;
    setWb(1, 10);
    settle();
    check("dr_ready1", sb.issue_ready, 0);
    check("dr_done1", sb.drain_done, 0);
    advance();
    setWb(1, 11);
    settle();
    check("dr_ready2", sb.issue_ready, 0);
    check("dr_done2", sb.drain_done, 0);
    advance();
    setWb(0, 0);
    settle();
    check("dr_done_pulse", sb.drain_done, 1);
    check("dr_ready3", sb.issue_ready, 0);
    advance();
    settle();
    check("dr_done_once", sb.drain_done, 0);
    check("dr_resume", sb.issue_ready, 1);
    check("dr_idle", sb.dbgState, 0);
    check("dr_stall", sb.stall_cycles, BYP ? 7 : 8);
    advance();

    // Reset while draining with two outstanding writes
    setIssue(1, 0, 0, 0, 0, 12, 1);
    advance();
    setIssue(1, 0, 0, 0, 0, 13, 1);
    sb.drain_req = 1'b1;
    advance();
    sb.drain_req = 1'b0;
    setIssue(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rd_pre_state", sb.dbgState, 1);
    check("rd_pre_out", sb.dbgOutstanding, 2);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    setIssue(1, 12, 1, 13, 1, 0, 0);
    settle();
    check("rd_state", sb.dbgState, 0);
    check("rd_out", sb.dbgOutstanding, 0);
    check("rd_busy", sb.busy, 0);
    check("rd_err", sb.err_underflow, 0);
    check("rd_stall", sb.stall_cycles, 0);
    check("rd_done", sb.drain_done, 0);
    check("rd_ready", sb.issue_ready, 1);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
